csr_machine_file: RTL and testbench

Parametrised machine/user-mode control-and-status register file for the Merlin RV core, successor to the stub CSR block. Implements real storage for the trap CSRs, 64-bit cycle/instret counters, and CSRRW/RS/RC read-modify-write. Sits beside the execute stage: the decoder drives the CSR access, and the trap/retire logic drives trap entry, mret and instruction-retire events.

---
 rtl/csr_pkg.sv | 34 +++
 rtl/csr_counter64.sv | 25 ++
 rtl/csr_machine_file.sv | 186 ++++++++++++++++++
 tb/tb_csr_machine_file.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared encodings for the machine/user CSR file: addresses, access ops, privilege levels, mstatus fields.
// Latency: n/a (constants only).
// Backpressure: n/a.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [1:0] CSR_OP_READ  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with increment enable and independent low/high word load strobes.
// Latency: load or increment visible one clk edge later.
// Backpressure: none; any load strobe suppresses that cycle's increment, unloaded half holds.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        ld_lo,
    input  logic        ld_hi,
    input  logic [63:0] ld_dat,
    output logic [63:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (ld_lo || ld_hi) begin
            if (ld_lo) cnt[31:0]  <= ld_dat[31:0];
            if (ld_hi) cnt[63:32] <= ld_dat[63:32];
        end else if (inc) begin
            cnt <= cnt + 64'd1;
        end
    end

endmodule

// File: rtl/csr_machine_file.sv
// Machine/user CSR file: trap CSRs, 64-bit cycle/instret counters, CSRRW/RS/RC read-modify-write.
// Latency: reads combinational (pre-write value); writes, traps and mret commit on the next clk_i edge.
// Backpressure: none; clk_en_i low freezes all state.
module csr_machine_file
    import csr_pkg::*;
#(
    parameter int unsigned             C_XLEN        = 32,
    parameter logic [C_XLEN-1:0]       C_HART_ID     = '0,
    parameter logic [C_XLEN-1:0]       C_RESET_MTVEC = '0,
    parameter bit                      C_USER_MODE   = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clk_en_i,
    input  logic              access_i,
    input  logic [1:0]        op_i,
    input  logic [11:0]       addr_i,
    input  logic [C_XLEN-1:0] data_i,
    output logic [C_XLEN-1:0] data_o,
    output logic              illegal_access_o,
    input  logic              instret_i,
    input  logic              trap_i,
    input  logic              trap_irq_i,
    input  logic [4:0]        trap_cause_i,
    input  logic [C_XLEN-1:0] trap_pc_i,
    input  logic              mret_i,
    output logic [C_XLEN-1:0] trap_vector_o,
    output logic [C_XLEN-1:0] mepc_o,
    output logic              mie_o,
    output logic [1:0]        hpl_o
);

    localparam int XL = C_XLEN;
    localparam logic [1:0]    MXL        = (XL == 64) ? 2'b10 : 2'b01;
    localparam logic [XL-1:0] ALIGN_MASK = {{(XL-2){1'b1}}, 2'b00};

    logic [1:0]    hpl;
    logic          mie, mpie;
    logic [1:0]    mpp;
    logic [XL-1:0] mtvec, mscratch, mepc;
    logic          mcause_irq;
    logic [4:0]    mcause_code;
    logic [63:0]   cycle_cnt, instret_cnt, ld_dat;

    logic [XL-1:0] mstatus_val, misa_val, mcause_val, old_val, new_val;
    logic          impl, we, mpp_ok;
    logic          cyc_ld_lo, cyc_ld_hi, ins_ld_lo, ins_ld_hi;
    logic [1:0]    new_mpp;

    always_comb begin
        mstatus_val = '0;
        mstatus_val[MSTATUS_MIE]         = mie;
        mstatus_val[MSTATUS_MPIE]        = mpie;
        mstatus_val[MSTATUS_MPP_LO +: 2] = mpp;
        misa_val = '0;
        misa_val[XL-1 -: 2] = MXL;
        misa_val[8]  = 1'b1;
        misa_val[20] = C_USER_MODE;
        mcause_val = '0;
        mcause_val[XL-1] = mcause_irq;
        mcause_val[4:0]  = mcause_code;
    end

    // High-half aliases exist only on RV32; on RV64 they decode as unimplemented.
    always_comb begin
        old_val = '0;
        impl    = 1'b1;
        case (addr_i)
            CSR_MSTATUS:                old_val = mstatus_val;
            CSR_MISA:                   old_val = misa_val;
            CSR_MTVEC:                  old_val = mtvec;
            CSR_MSCRATCH:               old_val = mscratch;
            CSR_MEPC:                   old_val = mepc;
            CSR_MCAUSE:                 old_val = mcause_val;
            CSR_MCYCLE, CSR_CYCLE:      old_val = cycle_cnt[XL-1:0];
            CSR_MINSTRET, CSR_INSTRET:  old_val = instret_cnt[XL-1:0];
            CSR_MCYCLEH, CSR_CYCLEH: begin
                old_val = XL'(cycle_cnt[63:32]);
                impl    = (XL == 32);
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                old_val = XL'(instret_cnt[63:32]);
                impl    = (XL == 32);
            end
            CSR_MHARTID:                old_val = C_HART_ID;
            default:                    impl    = 1'b0;
        endcase
    end

    always_comb begin
        case (op_i)
            CSR_OP_WRITE: new_val = data_i;
            CSR_OP_SET:   new_val = old_val | data_i;
            default:      new_val = old_val & ~data_i;
        endcase
    end

    assign illegal_access_o = access_i &&
                              (!impl || (hpl < addr_i[9:8]) ||
                               (op_i != CSR_OP_READ && addr_i[11:10] == 2'b11));
    assign data_o = old_val;

    // Trap and mret own the cycle; a coincident CSR write is dropped.
    assign we = clk_en_i && access_i && !illegal_access_o && (op_i != CSR_OP_READ) &&
                !trap_i && !mret_i;

    assign new_mpp = new_val[MSTATUS_MPP_LO +: 2];
    assign mpp_ok  = (new_mpp == PRIV_M) || (C_USER_MODE && new_mpp == PRIV_U);

    assign ld_dat    = (XL == 64) ? 64'(new_val) : {2{new_val[31:0]}};
    assign cyc_ld_lo = we && (addr_i == CSR_MCYCLE);
    assign cyc_ld_hi = we && ((addr_i == CSR_MCYCLEH) || (XL == 64 && addr_i == CSR_MCYCLE));
    assign ins_ld_lo = we && (addr_i == CSR_MINSTRET);
    assign ins_ld_hi = we && ((addr_i == CSR_MINSTRETH) || (XL == 64 && addr_i == CSR_MINSTRET));

    csr_counter64 u_cycle (
        .clk    (clk_i),
        .rst    (reset_i),
        .inc    (clk_en_i),
        .ld_lo  (cyc_ld_lo),
        .ld_hi  (cyc_ld_hi),
        .ld_dat (ld_dat),
        .cnt    (cycle_cnt)
    );

    csr_counter64 u_instret (
        .clk    (clk_i),
        .rst    (reset_i),
        .inc    (clk_en_i && instret_i),
        .ld_lo  (ins_ld_lo),
        .ld_hi  (ins_ld_hi),
        .ld_dat (ld_dat),
        .cnt    (instret_cnt)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hpl         <= PRIV_M;
            mie         <= 1'b0;
            mpie        <= 1'b0;
            mpp         <= PRIV_M;
            mtvec       <= C_RESET_MTVEC;
            mscratch    <= '0;
            mepc        <= '0;
            mcause_irq  <= 1'b0;
            mcause_code <= '0;
        end else if (clk_en_i) begin
            if (trap_i) begin
                mepc        <= trap_pc_i & ALIGN_MASK;
                mcause_irq  <= trap_irq_i;
                mcause_code <= trap_cause_i;
                mpie        <= mie;
                mie         <= 1'b0;
                mpp         <= hpl;
                hpl         <= PRIV_M;
            end else if (mret_i) begin
                mie  <= mpie;
                mpie <= 1'b1;
                hpl  <= mpp;
                mpp  <= C_USER_MODE ? PRIV_U : PRIV_M;
            end else if (we) begin
                case (addr_i)
                    CSR_MSTATUS: begin
                        mie  <= new_val[MSTATUS_MIE];
                        mpie <= new_val[MSTATUS_MPIE];
                        if (mpp_ok) mpp <= new_mpp;
                    end
                    CSR_MTVEC:    mtvec    <= new_val & ALIGN_MASK;
                    CSR_MSCRATCH: mscratch <= new_val;
                    CSR_MEPC:     mepc     <= new_val & ALIGN_MASK;
                    CSR_MCAUSE: begin
                        mcause_irq  <= new_val[XL-1];
                        mcause_code <= new_val[4:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign trap_vector_o = mtvec;
    assign mepc_o        = mepc;
    assign mie_o         = mie;
    assign hpl_o         = hpl;

endmodule

// File: tb/tb_csr_machine_file.sv
// Scoreboard bench for csr_machine_file: driver pushes model predictions, negedge monitor pops and compares.
// Latency: n/a. Backpressure: n/a.
`timescale 1ns/1ps
module tb_csr_machine_file;

    localparam logic [31:0] HART = 32'd5;
    localparam logic [31:0] RVEC = 32'h0000_0100;

    typedef struct {
        bit          acc;
        bit          ill;
        logic [31:0] dat;
        logic [31:0] tvec;
        logic [31:0] mepc;
        bit          mie;
        logic [1:0]  hpl;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_i, clk_en_i, access_i, instret_i, trap_i, trap_irq_i, mret_i;
    logic [1:0]  op_i;
    logic [11:0] addr_i;
    logic [31:0] data_i, trap_pc_i, data_o, trap_vector_o, mepc_o;
    logic [4:0]  trap_cause_i;
    logic        illegal_access_o, mie_o;
    logic [1:0]  hpl_o;

    logic        w_reset, w_clk_en, w_acc, w_instret, w_trap, w_irq, w_mret, w_ill, w_mie;
    logic [1:0]  w_op, w_hpl;
    logic [11:0] w_addr;
    logic [4:0]  w_cause;
    logic [63:0] w_data_i, w_data_o, w_pc, w_tvec, w_mepc;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk_i = ~clk_i;

    csr_machine_file #(
        .C_XLEN(32), .C_HART_ID(HART), .C_RESET_MTVEC(RVEC), .C_USER_MODE(1'b1)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i), .access_i(access_i),
        .op_i(op_i), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
        .illegal_access_o(illegal_access_o), .instret_i(instret_i), .trap_i(trap_i),
        .trap_irq_i(trap_irq_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
        .mret_i(mret_i), .trap_vector_o(trap_vector_o), .mepc_o(mepc_o),
        .mie_o(mie_o), .hpl_o(hpl_o)
    );

    csr_machine_file #(
        .C_XLEN(64), .C_HART_ID(64'hABCD), .C_RESET_MTVEC(64'h0000_0001_0000_0040), .C_USER_MODE(1'b1)
    ) dut64 (
        .clk_i(clk_i), .reset_i(w_reset), .clk_en_i(w_clk_en), .access_i(w_acc),
        .op_i(w_op), .addr_i(w_addr), .data_i(w_data_i), .data_o(w_data_o),
        .illegal_access_o(w_ill), .instret_i(w_instret), .trap_i(w_trap),
        .trap_irq_i(w_irq), .trap_cause_i(w_cause), .trap_pc_i(w_pc),
        .mret_i(w_mret), .trap_vector_o(w_tvec), .mepc_o(w_mepc),
        .mie_o(w_mie), .hpl_o(w_hpl)
    );

    // Reference model: architectural state as plain variables.
    logic [1:0]  m_hpl, m_mpp;
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;

    function automatic void model_reset();
        m_hpl = 2'd3; m_mpp = 2'd3; m_mie = 0; m_mpie = 0;
        m_mtvec = RVEC; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_cyc = 0; m_ins = 0;
    endfunction

    function automatic void model_read(input logic [11:0] a, input logic [1:0] op,
                                       output bit ill, output logic [31:0] v);
        bit known = 1;
        v = 0;
        case (a)
            12'h300: v = 32'(m_mie) * 8 + 32'(m_mpie) * 128 + 32'(m_mpp) * 2048;
            12'h301: v = 32'h4010_0100;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'hB00, 12'hC00: v = m_cyc[31:0];
            12'hB80, 12'hC80: v = m_cyc[63:32];
            12'hB02, 12'hC02: v = m_ins[31:0];
            12'hB82, 12'hC82: v = m_ins[63:32];
            12'hF14: v = HART;
            default: known = 0;
        endcase
        ill = !known || (m_hpl < a[9:8]) || (op != 2'd0 && a[11:10] == 2'd3);
    endfunction

    function automatic void model_step(input bit en, input bit acc, input logic [1:0] op,
                                       input logic [11:0] a, input logic [31:0] d, input bit ir,
                                       input bit tr, input bit irq, input logic [4:0] cause,
                                       input logic [31:0] pc, input bit mr);
        bit ill, cyc_wr, ins_wr;
        logic [31:0] old, nv;
        cyc_wr = 0; ins_wr = 0;
        if (!en) return;
        model_read(a, op, ill, old);
        if (tr) begin
            m_mepc = pc & ~32'd3;
            m_mcause = {irq, 26'd0, cause};
            m_mpie = m_mie; m_mie = 0; m_mpp = m_hpl; m_hpl = 2'd3;
        end else if (mr) begin
            m_mie = m_mpie; m_mpie = 1; m_hpl = m_mpp; m_mpp = 2'd0;
        end else if (acc && !ill && op != 2'd0) begin
            case (op)
                2'd1:    nv = d;
                2'd2:    nv = old | d;
                default: nv = old & ~d;
            endcase
            case (a)
                12'h300: begin
                    m_mie = nv[3]; m_mpie = nv[7];
                    if (nv[12:11] == 2'd3 || nv[12:11] == 2'd0) m_mpp = nv[12:11];
                end
                12'h305: m_mtvec = nv & ~32'd3;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'd3;
                12'h342: m_mcause = nv & 32'h8000_001F;
                12'hB00: begin m_cyc = {m_cyc[63:32], nv}; cyc_wr = 1; end
                12'hB80: begin m_cyc = {nv, m_cyc[31:0]}; cyc_wr = 1; end
                12'hB02: begin m_ins = {m_ins[63:32], nv}; ins_wr = 1; end
                12'hB82: begin m_ins = {nv, m_ins[31:0]}; ins_wr = 1; end
                default: ;
            endcase
        end
        if (!cyc_wr) m_cyc = m_cyc + 1;
        if (ir && !ins_wr) m_ins = m_ins + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("illegal", 64'(illegal_access_o), 64'(mon_e.acc && mon_e.ill));
                if (mon_e.acc && !mon_e.ill) chk("data", 64'(data_o), 64'(mon_e.dat));
                chk("trap_vector", 64'(trap_vector_o), 64'(mon_e.tvec));
                chk("mepc", 64'(mepc_o), 64'(mon_e.mepc));
                chk("mie", 64'(mie_o), 64'(mon_e.mie));
                chk("hpl", 64'(hpl_o), 64'(mon_e.hpl));
            end else if (access_i) begin
                chk("unexpected_access", 64'(exp_q.size()), 64'd1);
            end
        end
    end

    task automatic do_cycle(input bit en, input bit acc, input logic [1:0] op,
                            input logic [11:0] a, input logic [31:0] d, input bit ir,
                            input bit tr, input bit irq, input logic [4:0] cause,
                            input logic [31:0] pc, input bit mr);
        exp_t e;
        clk_en_i = en; access_i = acc; op_i = op; addr_i = a; data_i = d; instret_i = ir;
        trap_i = tr; trap_irq_i = irq; trap_cause_i = cause; trap_pc_i = pc; mret_i = mr;
        model_read(a, op, e.ill, e.dat);
        e.acc = acc; e.tvec = m_mtvec; e.mepc = m_mepc; e.mie = m_mie; e.hpl = m_hpl;
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        model_step(en, acc, op, a, d, ir, tr, irq, cause, pc, mr);
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        do_cycle(1, 1, op, a, d, 0, 0, 0, 5'd0, 32'd0, 0);
    endtask

    logic [11:0] addrs [18] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02,
                                12'hC80, 12'hC82, 12'hF14, 12'h7C0, 12'h344, 12'hC01};
    bit          r_en, r_acc, r_ir, r_tr, r_irq, r_mr;
    logic [1:0]  r_op;
    logic [31:0] r_d, r_pc;
    logic [4:0]  r_cause;

    initial begin
        reset_i = 1; clk_en_i = 0; access_i = 0; op_i = 0; addr_i = 0; data_i = 0;
        instret_i = 0; trap_i = 0; trap_irq_i = 0; trap_cause_i = 0; trap_pc_i = 0; mret_i = 0;
        w_reset = 1; w_clk_en = 1; w_acc = 0; w_op = 0; w_addr = 0; w_data_i = 0;
        w_instret = 0; w_trap = 0; w_irq = 0; w_cause = 0; w_pc = 0; w_mret = 0;
        #1;
        chk("rst_tvec", 64'(trap_vector_o), 64'(RVEC));
        chk("rst_mepc", 64'(mepc_o), 64'd0);
        chk("rst_mie", 64'(mie_o), 64'd0);
        chk("rst_hpl", 64'(hpl_o), 64'd3);
        @(posedge clk_i); #1;
        reset_i = 0;
        model_reset();

        csr(2'd0, 12'h300, 0); csr(2'd0, 12'h305, 0); csr(2'd0, 12'hF14, 0);
        csr(2'd1, 12'h340, 32'hDEADBEEF); csr(2'd2, 12'h340, 32'h0000000F);
        csr(2'd0, 12'h340, 0); csr(2'd3, 12'h340, 32'h000000F0); csr(2'd0, 12'h340, 0);
        csr(2'd1, 12'hB00, 32'hFFFFFFFF); csr(2'd1, 12'hB80, 32'h0);
        do_cycle(1, 0, 2'd0, 12'h0, 0, 1, 0, 0, 5'd0, 0, 0);
        do_cycle(1, 0, 2'd0, 12'h0, 0, 1, 0, 0, 5'd0, 0, 0);
        csr(2'd0, 12'hB80, 0); csr(2'd0, 12'hB00, 0);
        for (int i = 0; i < 5; i++) do_cycle(0, 1, 2'd0, 12'hB00, 0, 1, 0, 0, 5'd0, 0, 0);
        csr(2'd0, 12'hB02, 0);

        csr(2'd2, 12'h300, 32'h8);
        do_cycle(1, 1, 2'd1, 12'h340, 32'h12345678, 0, 1, 1, 5'd7, 32'h80000104, 0);
        csr(2'd0, 12'h341, 0); csr(2'd0, 12'h342, 0); csr(2'd0, 12'h300, 0); csr(2'd0, 12'h340, 0);
        csr(2'd3, 12'h300, 32'h1800);
        do_cycle(1, 0, 2'd0, 12'h0, 0, 0, 0, 0, 5'd0, 0, 1);
        csr(2'd0, 12'h340, 0); csr(2'd0, 12'hC00, 0); csr(2'd0, 12'hB00, 0);
        do_cycle(1, 0, 2'd0, 12'h0, 0, 0, 1, 0, 5'd8, 32'h80000200, 0);
        csr(2'd0, 12'h300, 0);
        csr(2'd1, 12'hC00, 32'h5); csr(2'd0, 12'h7C0, 0); csr(2'd1, 12'hF14, 32'h1);
        csr(2'd1, 12'h301, 32'h0); csr(2'd0, 12'hC00, 0); csr(2'd0, 12'h301, 0);

        for (int i = 0; i < 400; i++) begin
            r_en = ($urandom_range(7) != 0);
            r_acc = 1'($urandom_range(1));
            r_op = 2'($urandom_range(3));
            r_d = $urandom();
            r_ir = 1'($urandom_range(1));
            r_tr = ($urandom_range(15) == 0);
            r_irq = 1'($urandom_range(1));
            r_cause = 5'($urandom_range(31));
            r_pc = $urandom() & ~32'd3;
            r_mr = ($urandom_range(15) == 0);
            do_cycle(r_en, r_acc, r_op, addrs[$urandom_range(17)], r_d, r_ir, r_tr, r_irq,
                     r_cause, r_pc, r_mr);
        end

        csr(2'd1, 12'h305, 32'h2000); csr(2'd1, 12'h341, 32'h4000); csr(2'd1, 12'h300, 32'h88);
        do_cycle(1, 0, 2'd0, 12'h0, 0, 0, 0, 0, 5'd0, 0, 1);
        clk_en_i = 1; access_i = 1; op_i = 2'd1; addr_i = 12'h305; data_i = 32'h3000; mret_i = 0;
        #2 reset_i = 1;
        #1;
        chk("async_rst_tvec", 64'(trap_vector_o), 64'(RVEC));
        chk("async_rst_mepc", 64'(mepc_o), 64'd0);
        chk("async_rst_mie", 64'(mie_o), 64'd0);
        chk("async_rst_hpl", 64'(hpl_o), 64'd3);
        model_reset();
        @(posedge clk_i); #1;
        reset_i = 0; access_i = 0;
        csr(2'd0, 12'h300, 0); csr(2'd0, 12'h305, 0); csr(2'd0, 12'hB00, 0);
        access_i = 0;

        w_reset = 0; w_acc = 1; w_op = 2'd0; w_addr = 12'hB80;
        #1 chk("w_mcycleh_illegal", 64'(w_ill), 64'd1);
        chk("w_rst_tvec", w_tvec, 64'h0000_0001_0000_0040);
        w_addr = 12'h301;
        #1 chk("w_misa_legal", 64'(w_ill), 64'd0);
        chk("w_misa", w_data_o, 64'h8000_0000_0010_0100);
        w_addr = 12'hF14;
        #1 chk("w_hartid", w_data_o, 64'hABCD);
        w_op = 2'd1;
        #1 chk("w_hartid_write_illegal", 64'(w_ill), 64'd1);
        w_addr = 12'hB00; w_data_i = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk_i); #1;
        w_op = 2'd0;
        #1 chk("w_mcycle_full", w_data_o, 64'h1234_5678_9ABC_DEF0);
        @(posedge clk_i); #1;
        chk("w_mcycle_inc", w_data_o, 64'h1234_5678_9ABC_DEF1);
        w_acc = 0;

        @(negedge clk_i); #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
